// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: sequences the PC register, runs the imem req/ack
// handshake and hands fetched instructions to decode with trap/redirect/timeout handling.
module fetch_ctrl #(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
    parameter int          TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        trap,
    output logic        fetch_err,
    output logic [1:0]  dbg_state
);

    // Handshakes: imem_req/imem_ack completes a fetch in any cycle both are high;
    // instr_valid/instr_ready transfers an instruction when both are high and stall is low.

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fetch_err_q, fetch_err_d;
    logic        flush;
    logic        timeout_hit;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        instr_d     = instr_q;
        fetch_err_d = 1'b0;
        pc_next     = pc;
        imem_req    = 1'b0;
        flush       = 1'b0;
        timeout_hit = (state_q == ST_FETCH) && !imem_ack && (wait_cnt_q == WAIT_LAST);

        case (state_q)
            ST_BOOT: begin
                state_d    = ST_FETCH;
                wait_cnt_d = 8'd0;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d    = imem_rdata;
                    wait_cnt_d = 8'd0;
                    state_d    = ST_VALID;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_VALID: begin
                if (instr_ready && !stall) begin
                    pc_next = pc + 32'd4;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_BOOT;
        endcase

        // Events override the per-state outcome; a same-cycle ack is dropped.
        if (state_q != ST_BOOT) begin
            if (trap) begin
                pc_next = TRAP_VECTOR;
                flush   = 1'b1;
            end else if (timeout_hit) begin
                pc_next     = TRAP_VECTOR;
                fetch_err_d = 1'b1;
                flush       = 1'b1;
            end else if (redirect) begin
                flush = 1'b1;
                if (redirect_target[1:0] == 2'b00) begin
                    pc_next = redirect_target;
                end else begin
                    pc_next     = TRAP_VECTOR;
                    fetch_err_d = 1'b1;
                end
            end
        end

        if (flush) begin
            state_d    = ST_FETCH;
            wait_cnt_d = 8'd0;
            instr_d    = instr_q;
        end

        instr_valid_d = (state_d == ST_VALID);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            wait_cnt_q    <= 8'd0;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    assign imem_addr   = pc;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign fetch_err   = fetch_err_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that sequences the program counter register. It computes `pc_next` for the PC register, and runs a request/acknowledge handshake with instruction memory. It presents the fetched instruction to decode through a valid/ready handshake and applies stall, redirect (branch/jump), trap and fetch-timeout events with fixed priority. It sits between the PC register, instruction memory and the decode stage.

## Interface
Parameters:
- `TRAP_VECTOR`, default `32'h0000_0100`: PC loaded on trap, misaligned redirect or fetch timeout; bits[1:0] must be 0.
- `TIMEOUT`, default `16`: maximum cycles `imem_req` may wait for `imem_ack`; range 2..255.

Ports:
- `clk`, input, 1: clock, rising edge.
- `reset`, input, 1: reset, asynchronous, active-high.
- `pc`, input, 32: current PC from the PC register.
- `pc_next`, output, 32: next PC to the PC register; combinational.
- `imem_req`, output, 1: fetch request.
- `imem_addr`, output, 32: fetch address; equals `pc` while `imem_req` = 1.
- `imem_ack`, input, 1: memory response valid; meaningful only while `imem_req` = 1.
- `imem_rdata`, input, 32: instruction word; sampled when `imem_ack` = 1.
- `instr`, output, 32: registered instruction to decode.
- `instr_valid`, output, 1: `instr` holds a live instruction.
- `instr_ready`, input, 1: decode accepts `instr`.
- `stall`, input, 1: pipeline hazard; blocks consumption.
- `redirect`, input, 1: branch/jump taken.
- `redirect_target`, input, 32: destination for `redirect`.
- `trap`, input, 1: exception/interrupt request.
- `fetch_err`, output, 1: one-cycle pulse on misaligned redirect or timeout.

## Operation
- **Reset values:** state BOOT, `imem_req` = 0, `instr_valid` = 0, `instr` = 0, `fetch_err` = 0, wait counter = 0, and `pc_next` = `pc`.
- **FSM states:** BOOT, FETCH, VALID.
- **BOOT:** no request; `pc_next` = `pc`. Moves to FETCH unconditionally on the next edge.
- **FETCH:** `imem_req` = 1, `imem_addr` = `pc`, and `pc_next` = `pc`.
  - On `imem_ack`: capture `imem_rdata` into `instr`, clear the counter, and go to VALID.
  - Otherwise the counter increments.
  - When the counter reaches `TIMEOUT - 1` without an ack, take the timeout event.
- **VALID:** `instr_valid` = 1 and `instr` is stable.
  - Consume occurs when `instr_ready` = 1 and `stall` = 0: `pc_next` = `pc + 4`, modulo 2^32 (`32'hFFFF_FFFC` wraps to 0), then go to FETCH.
  - Otherwise hold, with `pc_next` = `pc`.
- **Event priority (FETCH or VALID; events are ignored in BOOT):** trap > timeout > redirect > consume > hold.
  - **trap:** `pc_next` = `TRAP_VECTOR`.
  - **timeout:** `pc_next` = `TRAP_VECTOR` and `fetch_err` pulses.
  - **redirect with `redirect_target[1:0]` = 0:** `pc_next` = `redirect_target`.
  - **redirect with `redirect_target[1:0]` ≠ 0:** `pc_next` = `TRAP_VECTOR` and `fetch_err` pulses.
  - For every event: next state FETCH, counter cleared, and `instr_valid` = 0 from the next cycle. Any `imem_ack` or `imem_rdata` in the same cycle is discarded.
- **`stall` behaviour:** affects only VALID consumption. It does not block trap or redirect, which flush the held instruction.
- **Memory cancellation:** dropping `imem_req` cancels the outstanding access. Memory must not ack a cancelled request.

## Timing
- All state, `instr`, `instr_valid` and `fetch_err` are registered. `pc_next`, `imem_req` and `imem_addr` are decoded from state and inputs in the same cycle.
- **After reset deasserts:** edge 1 enters FETCH. With a zero-wait ack, edge 2 enters VALID and `instr` appears.
- **Throughput:** at most one instruction per 2 cycles, plus one cycle per memory wait state.
- **Redirect or trap in cycle N:** PC = target after edge N+1, and `imem_req` with the new address in cycle N+1.
- **Reset asserted mid-fetch:** immediately forces BOOT and drops `imem_req` and `instr_valid` asynchronously. The in-flight access is abandoned.

## Test plan
- **Boot fetch:** release reset with `imem_ack` tied high and `imem_rdata` = `32'h00A00093`. Required: `imem_addr` = 0 in cycle 1, `instr_valid` = 1 with `instr` = `32'h00A00093` in cycle 2, and PC = 4 after consumption.
- **Stall:** hold `stall` = 1 for 3 cycles in VALID with `instr_ready` = 1. Required: `instr_valid` stays 1, `instr` is unchanged, `pc_next` = `pc`; PC advances by 4 one edge after `stall` drops.
- **Redirect:**
  - Redirect to `32'h0000_0040` while in FETCH with a same-cycle ack. Required: data discarded, next `imem_addr` = `32'h40`.
  - Redirect to `32'h0000_0042`. Required: `fetch_err` pulse and PC = `32'h100`.
- **Trap priority:** assert `trap`, `redirect` and consume together. Required: PC = `TRAP_VECTOR`.
- **Timeout:** never ack. Required: `imem_req` high for exactly 16 cycles, then `fetch_err` pulses, PC = `32'h100`, and a new request follows.
- **Wrap and async reset:**
  - Wrap: PC = `32'hFFFF_FFFC` and consume. Required: PC = 0.
  - Async reset: assert reset between clock edges during FETCH. Required: `imem_req` drops immediately and state returns to BOOT.
